// File: rtl/core_types_pkg.sv
// ----------------------------------------------------------------------------
// core_types_pkg
//   Shared core-wide constants and types for the physical register file (PRF)
//   and its read-request plumbing.
//
//   PRF_BANK_COUNT      number of PRF banks (each bank has 2 read ports)
//   LOG_PRF_BANK_COUNT  log2 of the bank count; the bank of a PR is its low bits
//   LOG_PR_COUNT        width of a physical register tag
//   prf_read_req_t      one buffered read request: pending flag plus PR tag
//   pr_bank()           bank index of a PR tag
// ----------------------------------------------------------------------------
package core_types_pkg;

  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int LOG_PR_COUNT       = 7;

  typedef struct packed {
    logic                    valid;
    logic [LOG_PR_COUNT-1:0] PR;
  } prf_read_req_t;

  // PRs are interleaved across banks on their low-order bits.
  function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(
    input logic [LOG_PR_COUNT-1:0] pr
  );
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

endpackage : core_types_pkg

// File: rtl/prf_read_req_arbiter_picker.sv
// ----------------------------------------------------------------------------
// rr_two_grant_picker
//   Round-robin picker that selects up to two requesters per cycle.
//   Scanning starts at ptr and wraps; the first eligible slot is grant0,
//   the second eligible slot is grant1. next_ptr points one past the last
//   slot granted, or equals ptr when nothing is granted.
//
//   Ports:
//     eligible  in   [SLOT_COUNT-1:0]      slots requesting this resource
//     ptr       in   [LOG_SLOT_COUNT-1:0]  current round-robin start slot
//     grant0    out  [SLOT_COUNT-1:0]      one-hot (or zero) first grant
//     grant1    out  [SLOT_COUNT-1:0]      one-hot (or zero) second grant
//     next_ptr  out  [LOG_SLOT_COUNT-1:0]  pointer to load at the clock edge
//
//   SLOT_COUNT must be 2**LOG_SLOT_COUNT so that the scan index wraps by
//   natural overflow of a LOG_SLOT_COUNT-bit adder.
// ----------------------------------------------------------------------------
module rr_two_grant_picker #(
  parameter int SLOT_COUNT     = 8,
  parameter int LOG_SLOT_COUNT = 3
) (
  input  logic [SLOT_COUNT-1:0]     eligible,
  input  logic [LOG_SLOT_COUNT-1:0] ptr,
  output logic [SLOT_COUNT-1:0]     grant0,
  output logic [SLOT_COUNT-1:0]     grant1,
  output logic [LOG_SLOT_COUNT-1:0] next_ptr
);

  always_comb begin
    logic [LOG_SLOT_COUNT-1:0] idx;
    logic                      found0;
    logic                      found1;
    // NOTE: every output and temporary gets a default before the scan so no
    // path through the loop leaves a value unassigned (which would infer a latch).
    grant0   = '0;
    grant1   = '0;
    next_ptr = ptr;
    found0   = 1'b0;
    found1   = 1'b0;
    idx      = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      idx = ptr + LOG_SLOT_COUNT'(i);
      if (eligible[idx]) begin
        if (!found0) begin
          grant0[idx] = 1'b1;
          found0      = 1'b1;
          next_ptr    = idx + 1'b1;
        end else if (!found1) begin
          grant1[idx] = 1'b1;
          found1      = 1'b1;
          next_ptr    = idx + 1'b1;
        end
      end
    end
  end

endmodule : rr_two_grant_picker

// File: rtl/prf_read_req_arbiter.sv
// ----------------------------------------------------------------------------
// prf_read_req_arbiter
//   Shares the two read ports of each PRF bank among REQUESTER_COUNT
//   execution pipelines. Each pipeline may post operand A (op 0) and
//   operand B (op 1) read requests; each (requester, op) pair owns one
//   buffering slot, slot index s = 2*r + op. Pending slots are arbitrated
//   per bank with an independent two-grant round-robin picker, and the
//   winners drive that bank's read ports combinationally. A registered ack
//   with the port number follows one cycle after the grant, which is the
//   cycle the PRF read data is on the bus.
//
//   Ports:
//     CLK, nRST                       clock, asynchronous active-low reset
//     req_valid_by_requester_by_op    one-cycle new-request pulse per slot
//     req_PR_by_requester_by_op       PR tag to read per slot
//     flush                           drop all pending and same-cycle requests,
//                                     suppress acks for this cycle's grants
//     ack_by_requester_by_op          registered: operand data valid this cycle
//     ack_port_by_requester_by_op     registered: port within the operand's bank
//     read_valid_by_bank_by_port      combinational PRF read enables
//     read_PR_by_bank_by_port         combinational PRF read addresses
// ----------------------------------------------------------------------------
module prf_read_req_arbiter
  import core_types_pkg::*;
#(
  parameter int REQUESTER_COUNT     = 4,
  parameter int LOG_REQUESTER_COUNT = 2
) (
  input  logic                                                 CLK,
  input  logic                                                 nRST,
  input  logic [REQUESTER_COUNT-1:0][1:0]                      req_valid_by_requester_by_op,
  input  logic [REQUESTER_COUNT-1:0][1:0][LOG_PR_COUNT-1:0]    req_PR_by_requester_by_op,
  input  logic                                                 flush,
  output logic [REQUESTER_COUNT-1:0][1:0]                      ack_by_requester_by_op,
  output logic [REQUESTER_COUNT-1:0][1:0]                      ack_port_by_requester_by_op,
  output logic [PRF_BANK_COUNT-1:0][1:0]                       read_valid_by_bank_by_port,
  output logic [PRF_BANK_COUNT-1:0][1:0][LOG_PR_COUNT-1:0]     read_PR_by_bank_by_port
);

  localparam int SLOT_COUNT     = 2 * REQUESTER_COUNT;
  localparam int LOG_SLOT_COUNT = LOG_REQUESTER_COUNT + 1;

  // --------------------------------------------------------------------------
  // Slot view of the request inputs. The packed [requester][op] layout puts
  // op in the low position, so the flat bit index is exactly s = 2*r + op.
  // --------------------------------------------------------------------------
  logic [SLOT_COUNT-1:0]                    req_valid_flat;
  logic [SLOT_COUNT-1:0][LOG_PR_COUNT-1:0]  req_pr_flat;

  assign req_valid_flat = req_valid_by_requester_by_op;
  assign req_pr_flat    = req_PR_by_requester_by_op;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  prf_read_req_t             slot_q   [SLOT_COUNT];
  prf_read_req_t             slot_d   [SLOT_COUNT];
  logic [LOG_SLOT_COUNT-1:0] rr_ptr_q [PRF_BANK_COUNT];
  logic [LOG_SLOT_COUNT-1:0] rr_ptr_d [PRF_BANK_COUNT];
  logic [SLOT_COUNT-1:0]     ack_q;
  logic [SLOT_COUNT-1:0]     ack_d;
  logic [SLOT_COUNT-1:0]     ack_port_q;
  logic [SLOT_COUNT-1:0]     ack_port_d;

  // --------------------------------------------------------------------------
  // Per-bank eligibility: pending slots whose PR maps to that bank.
  // --------------------------------------------------------------------------
  logic [SLOT_COUNT-1:0] eligible [PRF_BANK_COUNT];

  always_comb begin
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      eligible[b] = '0;
      for (int s = 0; s < SLOT_COUNT; s++) begin
        eligible[b][s] = slot_q[s].valid &&
                         (pr_bank(slot_q[s].PR) == LOG_PRF_BANK_COUNT'(b));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Independent round-robin picker per bank.
  // --------------------------------------------------------------------------
  logic [SLOT_COUNT-1:0] grant0 [PRF_BANK_COUNT];
  logic [SLOT_COUNT-1:0] grant1 [PRF_BANK_COUNT];

  for (genvar gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank
    rr_two_grant_picker #(
      .SLOT_COUNT     (SLOT_COUNT),
      .LOG_SLOT_COUNT (LOG_SLOT_COUNT)
    ) u_picker (
      .eligible (eligible[gb]),
      .ptr      (rr_ptr_q[gb]),
      .grant0   (grant0[gb]),
      .grant1   (grant1[gb]),
      .next_ptr (rr_ptr_d[gb])
    );
  end

  // --------------------------------------------------------------------------
  // PRF read ports. Grants are one-hot, so an AND-OR mux selects the PR;
  // an idle port naturally drives PR 0.
  // --------------------------------------------------------------------------
  always_comb begin
    read_valid_by_bank_by_port = '0;
    read_PR_by_bank_by_port    = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      read_valid_by_bank_by_port[b][0] = |grant0[b];
      read_valid_by_bank_by_port[b][1] = |grant1[b];
      for (int s = 0; s < SLOT_COUNT; s++) begin
        read_PR_by_bank_by_port[b][0] = read_PR_by_bank_by_port[b][0] |
                                        (grant0[b][s] ? slot_q[s].PR : '0);
        read_PR_by_bank_by_port[b][1] = read_PR_by_bank_by_port[b][1] |
                                        (grant1[b][s] ? slot_q[s].PR : '0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-slot grant summary. A slot sits in exactly one bank, so at most one
  // picker can grant it; port 1 is identified by grant1.
  // --------------------------------------------------------------------------
  logic [SLOT_COUNT-1:0] slot_granted;
  logic [SLOT_COUNT-1:0] slot_port;

  always_comb begin
    slot_granted = '0;
    slot_port    = '0;
    for (int s = 0; s < SLOT_COUNT; s++) begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        slot_granted[s] = slot_granted[s] | grant0[b][s] | grant1[b][s];
        slot_port[s]    = slot_port[s] | grant1[b][s];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state: grant clears the pending bit; flush clears everything,
  // including requests arriving in the same cycle. Otherwise a new pulse
  // sets pending and captures the PR (a pulse cannot target a slot being
  // granted, since that slot is still pending).
  // --------------------------------------------------------------------------
  always_comb begin
    for (int s = 0; s < SLOT_COUNT; s++) begin
      slot_d[s] = slot_q[s];
      if (slot_granted[s]) begin
        slot_d[s].valid = 1'b0;
      end
      if (flush) begin
        slot_d[s].valid = 1'b0;
      end else if (req_valid_flat[s]) begin
        slot_d[s].valid = 1'b1;
        slot_d[s].PR    = req_pr_flat[s];
      end
    end
    ack_d      = slot_granted & ~{SLOT_COUNT{flush}};
    ack_port_d = ack_d & slot_port;
  end

  // --------------------------------------------------------------------------
  // Registers. The round-robin pointers keep advancing on grants during a
  // flush; only reset returns them to 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the slot array is a handful of flops, not a RAM, and its pending
      // bits gate the read ports, so every entry is reset explicitly.
      for (int s = 0; s < SLOT_COUNT; s++) begin
        slot_q[s] <= '0;
      end
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        rr_ptr_q[b] <= '0;
      end
      ack_q      <= '0;
      ack_port_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // the values computed before the edge, independent of statement order.
      slot_q     <= slot_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_q      <= ack_d;
      ack_port_q <= ack_port_d;
    end
  end

  assign ack_by_requester_by_op      = ack_q;
  assign ack_port_by_requester_by_op = ack_port_q;

  // --------------------------------------------------------------------------
  // Protocol check: a requester must not re-post a slot that is still
  // pending (the PR would be silently overwritten).
  // --------------------------------------------------------------------------
  for (genvar gs = 0; gs < SLOT_COUNT; gs++) begin : g_slot_chk
    a_no_req_on_pending : assert property (
      @(posedge CLK) disable iff (!nRST)
      !(req_valid_flat[gs] && slot_q[gs].valid)
    );
  end

endmodule : prf_read_req_arbiter

// File: doc/prf_read_req_arbiter.md
Name: prf_read_req_arbiter

Overview:
- Shares the physical register file read ports (2 per bank) among REQUESTER_COUNT execution pipelines, e.g. ALU reg, ALU imm, branch and LDU pipelines.
- Each pipeline posts up to two operand read requests (A, B). The arbiter buffers them, grants up to 2 per bank per cycle using round-robin, and drives the PRF bank read ports.
- It returns registered per-operand acks with port numbers, aligned to the cycle in which the PRF read data is valid.

Parameters:
- REQUESTER_COUNT, 4, number of pipelines sharing the PRF read ports.
- LOG_REQUESTER_COUNT, 2, $clog2(REQUESTER_COUNT).

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- req_valid_by_requester_by_op  input  [REQUESTER_COUNT-1:0][1:0]  one-cycle new-request pulse; op 0 = A, op 1 = B.
- req_PR_by_requester_by_op  input  [REQUESTER_COUNT-1:0][1:0][LOG_PR_COUNT-1:0]  PR to read; bank = PR[LOG_PRF_BANK_COUNT-1:0].
- flush  input  1  drop all pending requests and suppress next-cycle acks.
- ack_by_requester_by_op  output  [REQUESTER_COUNT-1:0][1:0]  registered; operand data is on the PRF read bus this cycle.
- ack_port_by_requester_by_op  output  [REQUESTER_COUNT-1:0][1:0]  registered; port (0/1) within the operand's bank.
- read_valid_by_bank_by_port  output  [PRF_BANK_COUNT-1:0][1:0]  combinational read enable to the PRF.
- read_PR_by_bank_by_port  output  [PRF_BANK_COUNT-1:0][1:0][LOG_PR_COUNT-1:0]  combinational; PR per port.

Behaviour:
- Slot index s = 2*r + op, giving 2*REQUESTER_COUNT slots. Each slot holds a pending bit and a PR register.
- Capture: a req_valid pulse in cycle T sets the slot's pending bit and latches the PR at the T edge. The slot is eligible from T+1.
- Pending requests hold until granted. A pulse on an already-pending slot is a protocol violation: an SVA assertion fires, and the PR is overwritten.
- Arbitration, per bank b, each cycle:
  - Eligible slots are the pending slots whose PR bank equals b.
  - Starting at rr_ptr[b] and wrapping modulo 2*REQUESTER_COUNT, the first eligible slot gets port 0 and the second gets port 1.
  - Unused ports drive read_valid=0 and PR=0.
- Grant effects at the clock edge:
  - Granted slots clear their pending bit.
  - rr_ptr[b] moves to (last granted slot + 1) mod 2*REQUESTER_COUNT, or stays unchanged if bank b granted nothing.
- Ack timing: for a grant in cycle T, ack=1 and ack_port=port in cycle T+1, matching the PRF's 1-cycle read latency.
- Total latency is 2 cycles minimum: request pulse at T, grant at T+1, ack at T+2.
- Acks are single-cycle pulses. A slot whose ack is 0 holds ack_port at 0.
- Same-cycle capture and grant on one slot cannot occur, because a new pulse only targets a non-pending slot.
- A slot may be re-requested in the cycle its ack is high: the pending bit was already cleared at the grant edge.
- flush in cycle T:
  - At the T edge, all pending bits clear, and cycle-T grants do not produce acks at T+1.
  - Requests pulsed in cycle T are also discarded.
  - rr pointers are retained.
  - read_valid outputs in cycle T still assert as computed. This is harmless because the PRF read is side-effect-free.
- Bank conflicts: more than 2 eligible slots in one bank leaves the extra slots pending. Round-robin guarantees each slot a grant within ceil((2*REQUESTER_COUNT)/2) cycles.
- Banks arbitrate independently, so up to 2*PRF_BANK_COUNT grants are possible per cycle.
- Reset (async, nRST=0): all pending bits, PR registers, rr pointers, acks and ack_ports are 0. read_valid is 0 because nothing is pending. Reset mid-operation discards all requests with no acks afterward.

Decomposition:
- core_types_pkg supplies PRF_BANK_COUNT, LOG_PRF_BANK_COUNT and LOG_PR_COUNT.
- Add a typedef to core_types_pkg: prf_read_req_t {valid, PR}.
- One natural sub-module is rr_two_grant_picker. It is parameterized by slot count. It takes an eligible vector and a pointer, and outputs two one-hot grants plus the next pointer. It is instantiated once per bank.

Test Plan:
- Single request:
  - Stimulus: r0 op A with PR 5 (bank 1) pulsed at cycle 0.
  - Response: read_valid[1][0]=1 with PR 5 at cycle 1; ack[0][0]=1, port 0 at cycle 2; all else quiet.
- Same-bank triple conflict:
  - Stimulus: slots 0, 1 and 2 request PRs 4, 8 and 12 (bank 0) at cycle 0.
  - Cycle 1: slots 0 and 1 granted on ports 0 and 1; rr_ptr[0]=2.
  - Cycle 2: slot 2 granted on port 0; acks follow one cycle later.
- Multi-bank parallelism:
  - Stimulus: eight slots with PRs 0–7, covering banks 0–3 twice each.
  - Response: all eight granted in cycle 1; all acks in cycle 2.
- Round-robin fairness:
  - Stimulus: slots 0–7 re-request bank 2 every time they are acked.
  - Response: over 16 cycles each slot receives exactly 4 grants, in rotating order.
- Flush:
  - Stimulus: pending slots 3 and 5, plus a new pulse on slot 6, with flush at cycle 1.
  - Response: no acks in cycle 2 and all pending bits 0; a slot 3 re-request at cycle 2 is acked at cycle 4.
- Async reset mid-operation:
  - Stimulus: nRST dropped between edges while 4 slots are pending.
  - Response: outputs 0 immediately and no acks after release; rr pointers are 0.
